secuenciador_melodia: RTL and testbench
=======================================

// Module: secuenciador_melodia
// PURPOSE
//  Plays a melody stored in ROM, one note at a time. For each note it drives the tone
//  frequency (Hz) and a sound enable into the downstream frequency divider.
//  Note timing comes from a tempo tick derived from the 50 MHz system clock.
//  Sits between the user controls (play/stop/loop) and the divider that generates the tone.
// PARAMETERS
//  CLK_HZ     50_000_000  system clock frequency (informational; used to derive TICK_CYC)
//  TICK_CYC   6_250_000   clk cycles per tick (120 BPM, 4 ticks/beat); override small in sim
//  MEL_LEN    32          ROM depth in entries
//  ADDR_W     5           ROM address width, 2**ADDR_W >= MEL_LEN
//  GAP_TICKS  1           silent ticks at the end of each note (SECUENCIADOR_GAP_EN only)
// PORTS
//  clk        in   1   system clock, 50 MHz
//  rst        in   1   synchronous, active-high reset
//  play       in   1   level; sampled in IDLE to start playback from address 0
//  stop       in   1   level; aborts playback, highest priority after rst
//  loop       in   1   level; sampled at melody end: 1 = restart at address 0, 0 = finish
//  freq       out  32  signed tone frequency in Hz; 0 when silent
//  sound_en   out  1   1 = divider output audible; 0 = mute (freq is 0 whenever this is 0)
//  note_idx   out  ADDR_W  address of the current entry
//  busy       out  1   high in LOAD/PLAY/GAP
//  done       out  1   one-cycle pulse when melody ends without looping
// BEHAVIOUR
//  ROM entry, 16 bits: [15:8] note code (0x00 = rest, 0xFF = end marker), [7:0] duration in ticks.
//  Duration 0 is treated as 1. Synchronous ROM read: address in cycle N, data in cycle N+1.
//  Note code maps to Hz through the package table; unmapped codes behave as a rest.
//  FSM states: IDLE, LOAD, PLAY, GAP, DONE.
//   IDLE -> LOAD when play=1 && stop=0; note_idx := 0.
//   LOAD (1 cycle, ROM latency) -> PLAY; or -> DONE/LOAD@0 if end marker or note_idx==MEL_LEN.
//   PLAY: freq = table[code] (0 for rest); sound_en = (code != rest).
//    tick_cnt and dur_cnt are cleared on PLAY entry.
//    Slot lasts exactly dur*TICK_CYC cycles, then note_idx+1 and -> LOAD.
//   DONE: done pulses 1 cycle on entry; -> IDLE once play=0.
//  End of melody: end marker or wrap past MEL_LEN-1. With loop=1 -> LOAD at address 0
//   (no done pulse); with loop=0 -> DONE.
//  Latency: play sampled at cycle N -> LOAD at N+1 -> PLAY with valid freq at N+2.
//  stop=1 in any state -> IDLE next cycle, freq=0, sound_en=0. stop and play together -> stop wins.
//  Reset (any time, including mid-note): state=IDLE, freq=0, sound_en=0, note_idx=0, busy=0,
//   done=0, all counters 0.
//  Width rules: tick_cnt sized for TICK_CYC-1; dur_cnt 8 bits; freq zero-extended from the
//   table's 16-bit Hz value.
//  Invariant: freq==0 whenever sound_en==0 (the divider's N=freq_in/(2*freq) is never evaluated live).
// CONFIGURATION
//  SECUENCIADOR_GAP_EN defined:
//   - The final GAP_TICKS ticks of each note slot enter GAP: sound_en=0, freq=0.
//   - The total slot length is unchanged.
//   - No gap is inserted when dur <= GAP_TICKS.
//  Not defined: the GAP state is unreachable, and notes are legato (adjacent notes with no silence).
// STRUCTURE
//  Package musica_pkg:
//   - note code constants (REST=0x00, END=0xFF, C4=1 ... B5=24);
//   - note->Hz table (e.g. A4 code 10 -> 440);
//   - FSM state encoding;
//   - ROM entry field offsets.
//  Sub-module rom_melodia: synchronous MEL_LEN x 16 ROM, initialised from a hex file.
//  Top-level FSM, tempo counter and duration counter stay in this module.
// TESTING (TICK_CYC=4, MEL_LEN=8)
//  1) ROM {A4/2, C4/1, END}, play=1, loop=0:
//     - freq=440 for 8 cycles, then 262 for 4 cycles;
//     - done pulses once, then the block returns to IDLE.
//  2) Rest entry {REST/3}: sound_en=0 and freq=0 for 12 cycles; busy=1 throughout.
//  3) loop=1, 3-entry melody: after the last note, note_idx returns to 0 with no done pulse.
//     Set loop=0 -> DONE at the next end of melody.
//  4) stop=1 mid-note (cycle 5 of A4): IDLE next cycle, freq=0. play and stop asserted
//     together: the block stays IDLE.
//  5) rst during PLAY: all outputs at reset values in the following cycle. Replay starts at
//     address 0 with the full first-note duration.
//  6) SECUENCIADOR_GAP_EN, GAP_TICKS=1, A4/3:
//     - 8 cycles at 440, then 4 cycles with sound_en=0;
//     - A4/1 entry: 4 cycles at 440, no gap.

Source files
------------

// File: rtl/secuenciador_melodia_pkg.sv
// musica_pkg: shared definitions for the melody sequencer.
//   - note code constants (REST, END, C4..B5)
//   - note code -> tone frequency (Hz) lookup
//   - FSM state encoding
//   - bit offsets of the 16-bit ROM entry fields
package musica_pkg;

    // Note codes. Codes 1..24 cover C4..B5 chromatically.
    localparam logic [7:0] NOTE_REST = 8'h00;
    localparam logic [7:0] NOTE_END  = 8'hFF;
    localparam logic [7:0] NOTE_C4 = 8'd1,  NOTE_CS4 = 8'd2,  NOTE_D4 = 8'd3,  NOTE_DS4 = 8'd4;
    localparam logic [7:0] NOTE_E4 = 8'd5,  NOTE_F4  = 8'd6,  NOTE_FS4 = 8'd7, NOTE_G4  = 8'd8;
    localparam logic [7:0] NOTE_GS4 = 8'd9, NOTE_A4  = 8'd10, NOTE_AS4 = 8'd11, NOTE_B4 = 8'd12;
    localparam logic [7:0] NOTE_C5 = 8'd13, NOTE_CS5 = 8'd14, NOTE_D5 = 8'd15, NOTE_DS5 = 8'd16;
    localparam logic [7:0] NOTE_E5 = 8'd17, NOTE_F5  = 8'd18, NOTE_FS5 = 8'd19, NOTE_G5 = 8'd20;
    localparam logic [7:0] NOTE_GS5 = 8'd21, NOTE_A5 = 8'd22, NOTE_AS5 = 8'd23, NOTE_B5 = 8'd24;

    // ROM entry layout: [15:8] note code, [7:0] duration in ticks.
    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 8;
    localparam int DUR_MSB  = 7;
    localparam int DUR_LSB  = 0;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Equal-tempered frequencies rounded to the nearest Hz.
    // Rest, end marker and any unmapped code return 0, which the
    // sequencer treats as silence.
    function automatic logic [15:0] note_hz(input logic [7:0] code);
        case (code)
            8'd1:    note_hz = 16'd262;
            8'd2:    note_hz = 16'd277;
            8'd3:    note_hz = 16'd294;
            8'd4:    note_hz = 16'd311;
            8'd5:    note_hz = 16'd330;
            8'd6:    note_hz = 16'd349;
            8'd7:    note_hz = 16'd370;
            8'd8:    note_hz = 16'd392;
            8'd9:    note_hz = 16'd415;
            8'd10:   note_hz = 16'd440;
            8'd11:   note_hz = 16'd466;
            8'd12:   note_hz = 16'd494;
            8'd13:   note_hz = 16'd523;
            8'd14:   note_hz = 16'd554;
            8'd15:   note_hz = 16'd587;
            8'd16:   note_hz = 16'd622;
            8'd17:   note_hz = 16'd659;
            8'd18:   note_hz = 16'd698;
            8'd19:   note_hz = 16'd740;
            8'd20:   note_hz = 16'd784;
            8'd21:   note_hz = 16'd831;
            8'd22:   note_hz = 16'd880;
            8'd23:   note_hz = 16'd932;
            8'd24:   note_hz = 16'd988;
            default: note_hz = 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/secuenciador_melodia_if.sv
// secuenciador_melodia_if: control and tone bus of the melody sequencer.
//   play, stop, loop : user controls (master -> slave)
//   freq, sound_en   : tone request to the frequency divider
//   note_idx, busy, done : playback status
//   dbg_state        : current FSM state, for observation only
//
// Contract: play/stop/loop are levels, sampled on every rising clk edge
// (no valid/ready handshake). Whenever sound_en is 0, freq is 0, so the
// divider never evaluates a live division by zero. done is a single-cycle
// pulse; all other outputs are levels.
interface secuenciador_melodia_if #(
    parameter int ADDR_W = 5
);
    import musica_pkg::*;

    logic               play;
    logic               stop;
    logic               loop;
    logic signed [31:0] freq;
    logic               sound_en;
    logic [ADDR_W-1:0]  note_idx;
    logic               busy;
    logic               done;
    state_t             dbg_state;

    modport master (
        output play, stop, loop,
        input  freq, sound_en, note_idx, busy, done, dbg_state
    );

    modport slave (
        input  play, stop, loop,
        output freq, sound_en, note_idx, busy, done, dbg_state
    );

endinterface

// File: rtl/secuenciador_melodia_rom.sv
// rom_melodia: synchronous MEL_LEN x 16 melody ROM.
// The melody hex image is supplied as the flat ROM_INIT vector (entry i in
// bits [16*i +: 16]), so the contents are fixed at elaboration time.
// Ports:
//   clk  in  1       clock
//   addr in  ADDR_W  read address, presented in cycle N
//   data out 16      entry at addr, valid in cycle N+1 (0 beyond MEL_LEN)
module rom_melodia #(
    parameter int                    MEL_LEN  = 32,
    parameter int                    ADDR_W   = 5,
    parameter logic [16*MEL_LEN-1:0] ROM_INIT = '0
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    output logic [15:0]       data
);

    always_ff @(posedge clk) begin
        if (32'(addr) < 32'(MEL_LEN)) begin
            data <= ROM_INIT[{addr, 4'b0000} +: 16];
        end else begin
            data <= 16'd0;
        end
    end

endmodule

// File: rtl/secuenciador_melodia.sv
// secuenciador_melodia: plays a ROM melody one note at a time and drives the
// tone frequency and sound enable of the downstream frequency divider.
// Ports:
//   clk  in  1   system clock
//   rst  in  1   synchronous, active-high reset
//   bus  slave modport of secuenciador_melodia_if (play/stop/loop in;
//        freq/sound_en/note_idx/busy/done/dbg_state out)
// Optional feature: define SECUENCIADOR_GAP_EN to silence the last GAP_TICKS
// ticks of every note slot longer than GAP_TICKS (slot length unchanged).
// Without it notes are legato and the GAP state is never entered.
module secuenciador_melodia
    import musica_pkg::*;
#(
    parameter int                    CLK_HZ    = 50_000_000,
    parameter int                    TICK_CYC  = CLK_HZ / 8,
    parameter int                    MEL_LEN   = 32,
    parameter int                    ADDR_W    = 5,
    parameter int                    GAP_TICKS = 1,
    parameter logic [16*MEL_LEN-1:0] ROM_INIT  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    secuenciador_melodia_if.slave bus
);

`ifdef SECUENCIADOR_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    localparam int         TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [8:0] GAP9   = 9'(GAP_TICKS);

    state_t            state, state_d;
    logic [ADDR_W-1:0] note_idx, idx_d;
    logic              wrap_q, wrap_d;
    logic              load_note;
    logic              done_q;
    logic [15:0]       rom_q;
    logic [7:0]        rom_code, rom_dur;
    logic [15:0]       cur_hz;
    logic [7:0]        cur_dur;
    logic [TICK_W-1:0] tick_cnt;
    logic [7:0]        dur_cnt;
    logic              tick, slot_end, gap_start, last_addr, counting;

    // The ROM is addressed with the next index so that the entry is already
    // on rom_q during the LOAD cycle, where the end marker is decided.
    rom_melodia #(
        .MEL_LEN  (MEL_LEN),
        .ADDR_W   (ADDR_W),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (idx_d),
        .data (rom_q)
    );

    assign rom_code  = rom_q[NOTE_MSB:NOTE_LSB];
    assign rom_dur   = rom_q[DUR_MSB:DUR_LSB];
    assign tick      = (tick_cnt == TICK_W'(TICK_CYC - 1));
    assign slot_end  = tick && (dur_cnt == cur_dur - 8'd1);
    assign last_addr = (note_idx == ADDR_W'(MEL_LEN - 1));
    // Enter the gap once dur-GAP_TICKS ticks of the slot have elapsed.
    assign gap_start = GAP_EN && tick && ({1'b0, cur_dur} > GAP9) &&
                       ({1'b0, dur_cnt} == {1'b0, cur_dur} - GAP9 - 9'd1);
    // Counters run across PLAY and GAP of one slot and are zero otherwise,
    // so they always start from 0 on PLAY entry.
    assign counting  = ((state == ST_PLAY) || (state == ST_GAP)) &&
                       ((state_d == ST_PLAY) || (state_d == ST_GAP));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            note_idx <= '0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
            cur_hz   <= 16'd0;
            cur_dur  <= 8'd0;
            tick_cnt <= '0;
            dur_cnt  <= 8'd0;
        end else begin
            state    <= state_d;
            note_idx <= idx_d;
            wrap_q   <= wrap_d;
            done_q   <= (state_d == ST_DONE) && (state != ST_DONE);
            if (load_note) begin
                cur_hz  <= note_hz(rom_code);
                cur_dur <= (rom_dur == 8'd0) ? 8'd1 : rom_dur;
            end
            if (counting) begin
                if (tick) begin
                    tick_cnt <= '0;
                    dur_cnt  <= dur_cnt + 8'd1;
                end else begin
                    tick_cnt <= tick_cnt + 1'b1;
                end
            end else begin
                tick_cnt <= '0;
                dur_cnt  <= 8'd0;
            end
        end
    end

    always_comb begin
        state_d      = state;
        idx_d        = note_idx;
        wrap_d       = wrap_q;
        load_note    = 1'b0;
        bus.freq     = 32'sd0;
        bus.sound_en = 1'b0;
        bus.busy     = 1'b0;
        bus.done     = done_q;
        bus.note_idx = note_idx;
        bus.dbg_state = state;

        if (bus.stop) begin
            state_d = ST_IDLE;
            wrap_d  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.play) begin
                        state_d = ST_LOAD;
                        idx_d   = '0;
                        wrap_d  = 1'b0;
                    end
                end
                ST_LOAD: begin
                    // wrap_q marks that the previous slot was the last ROM entry.
                    if (wrap_q || (rom_code == NOTE_END)) begin
                        wrap_d = 1'b0;
                        if (bus.loop) begin
                            idx_d = '0;        // stay in LOAD while entry 0 is fetched
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        state_d   = ST_PLAY;
                        load_note = 1'b1;
                    end
                end
                ST_PLAY, ST_GAP: begin
                    if (slot_end) begin
                        state_d = ST_LOAD;
                        if (last_addr) begin
                            wrap_d = 1'b1;
                        end else begin
                            idx_d = note_idx + 1'b1;
                        end
                    end else if ((state == ST_PLAY) && gap_start) begin
                        state_d = ST_GAP;
                    end
                end
                ST_DONE: begin
                    if (!bus.play) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        case (state)
            ST_PLAY: begin
                bus.freq     = signed'({16'd0, cur_hz});
                bus.sound_en = (cur_hz != 16'd0);
                bus.busy     = 1'b1;
            end
            ST_LOAD, ST_GAP: bus.busy = 1'b1;
            default: bus.busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_secuenciador_melodia.sv
module tb_secuenciador_melodia;
    import musica_pkg::*;

    localparam int NDUT = 5;
    localparam int DA = 0;  // A4/2, C4/1, END
    localparam int DR = 1;  // REST/3, END
    localparam int DL = 2;  // C4/1, E4/1, G4/1, END
    localparam int DG = 3;  // A4/3, A4/1, END
    localparam int DW = 4;  // eight C4/0 entries, no end marker

    function automatic logic [127:0] rom_img(input int g);
        case (g)
            0:       return {80'h0, 16'hFF00, 16'h0101, 16'h0A02};
            1:       return {96'h0, 16'hFF00, 16'h0003};
            2:       return {64'h0, 16'hFF00, 16'h0801, 16'h0501, 16'h0101};
            3:       return {80'h0, 16'hFF00, 16'h0A01, 16'h0A03};
            4:       return {8{16'h0100}};
            default: return 128'h0;
        endcase
    endfunction

    // clock / reset / stimulus signals
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic play = 1'b0;
    logic stop = 1'b0;
    logic loop = 1'b0;
    always #5 clk = ~clk;

    logic signed [31:0] o_freq [NDUT];
    logic               o_snd  [NDUT];
    logic [2:0]         o_idx  [NDUT];
    logic               o_busy [NDUT];
    logic               o_done [NDUT];
    state_t             o_st   [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : gen_dut
        secuenciador_melodia_if #(.ADDR_W(3)) bus ();
        assign bus.play = play;
        assign bus.stop = stop;
        assign bus.loop = loop;
        secuenciador_melodia #(
            .TICK_CYC  (4),
            .MEL_LEN   (8),
            .ADDR_W    (3),
            .GAP_TICKS (1),
            .ROM_INIT  (rom_img(g))
        ) u_dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
        assign o_freq[g] = bus.freq;
        assign o_snd[g]  = bus.sound_en;
        assign o_idx[g]  = bus.note_idx;
        assign o_busy[g] = bus.busy;
        assign o_done[g] = bus.done;
        assign o_st[g]   = bus.dbg_state;
    end

    // scoreboard
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [vec %0d]: got %0d, expected %0d", name, v, act, exp);
        end
    endtask

    typedef struct {
        int     dut;
        bit     r;
        bit     p;
        bit     s;
        bit     l;
        int     n;
        state_t st;
        int     freq;
        bit     snd;
        int     idx;
        bit     busy;
        bit     done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input int dut, input bit r, input bit p, input bit s, input bit l,
                                input int n, input state_t st, input int freq, input bit snd,
                                input int idx, input bit busy, input bit done);
        vec_t v;
        v.dut = dut; v.r = r; v.p = p; v.s = s; v.l = l; v.n = n;
        v.st = st; v.freq = freq; v.snd = snd; v.idx = idx; v.busy = busy; v.done = done;
        vecs.push_back(v);
    endfunction

    initial begin
        int  cyc;
        bit  got_done;

        // ---- vector table: inputs hold for n cycles, each sample must match
        // 1) A4/2, C4/1, END, no loop
        add(DA, 1,0,0,0, 2, ST_IDLE, 0,   0, 0, 0, 0);
        add(DA, 0,1,0,0, 1, ST_LOAD, 0,   0, 0, 1, 0);
`ifdef SECUENCIADOR_GAP_EN
        add(DA, 0,1,0,0, 4, ST_PLAY, 440, 1, 0, 1, 0);
        add(DA, 0,1,0,0, 4, ST_GAP,  0,   0, 0, 1, 0);
`else
        add(DA, 0,1,0,0, 8, ST_PLAY, 440, 1, 0, 1, 0);
`endif
        add(DA, 0,1,0,0, 1, ST_LOAD, 0,   0, 1, 1, 0);
        add(DA, 0,1,0,0, 4, ST_PLAY, 262, 1, 1, 1, 0);
        add(DA, 0,1,0,0, 1, ST_LOAD, 0,   0, 2, 1, 0);
        add(DA, 0,1,0,0, 1, ST_DONE, 0,   0, 2, 0, 1);
        add(DA, 0,1,0,0, 2, ST_DONE, 0,   0, 2, 0, 0);
        add(DA, 0,0,0,0, 2, ST_IDLE, 0,   0, 2, 0, 0);
        // 2) rest entry REST/3
        add(DR, 1,0,0,0, 1, ST_IDLE, 0,   0, 0, 0, 0);
        add(DR, 0,1,0,0, 1, ST_LOAD, 0,   0, 0, 1, 0);
`ifdef SECUENCIADOR_GAP_EN
        add(DR, 0,1,0,0, 8, ST_PLAY, 0,   0, 0, 1, 0);
        add(DR, 0,1,0,0, 4, ST_GAP,  0,   0, 0, 1, 0);
`else
        add(DR, 0,1,0,0, 12, ST_PLAY, 0,  0, 0, 1, 0);
`endif
        add(DR, 0,1,0,0, 1, ST_LOAD, 0,   0, 1, 1, 0);
        add(DR, 0,1,0,0, 1, ST_DONE, 0,   0, 1, 0, 1);
        add(DR, 0,0,0,0, 1, ST_IDLE, 0,   0, 1, 0, 0);
        // 3) loop over a 3-note melody, then drop loop
        add(DL, 1,0,0,0, 1, ST_IDLE, 0,   0, 0, 0, 0);
        add(DL, 0,1,0,1, 1, ST_LOAD, 0,   0, 0, 1, 0);
        add(DL, 0,1,0,1, 4, ST_PLAY, 262, 1, 0, 1, 0);
        add(DL, 0,1,0,1, 1, ST_LOAD, 0,   0, 1, 1, 0);
        add(DL, 0,1,0,1, 4, ST_PLAY, 330, 1, 1, 1, 0);
        add(DL, 0,1,0,1, 1, ST_LOAD, 0,   0, 2, 1, 0);
        add(DL, 0,1,0,1, 4, ST_PLAY, 392, 1, 2, 1, 0);
        add(DL, 0,1,0,1, 1, ST_LOAD, 0,   0, 3, 1, 0);
        add(DL, 0,1,0,1, 1, ST_LOAD, 0,   0, 0, 1, 0);
        add(DL, 0,1,0,1, 4, ST_PLAY, 262, 1, 0, 1, 0);
        add(DL, 0,1,0,0, 1, ST_LOAD, 0,   0, 1, 1, 0);
        add(DL, 0,1,0,0, 4, ST_PLAY, 330, 1, 1, 1, 0);
        add(DL, 0,1,0,0, 1, ST_LOAD, 0,   0, 2, 1, 0);
        add(DL, 0,1,0,0, 4, ST_PLAY, 392, 1, 2, 1, 0);
        add(DL, 0,1,0,0, 1, ST_LOAD, 0,   0, 3, 1, 0);
        add(DL, 0,1,0,0, 1, ST_DONE, 0,   0, 3, 0, 1);
        add(DL, 0,0,0,0, 1, ST_IDLE, 0,   0, 3, 0, 0);
        // 4) stop in cycle 5 of A4, then play+stop together
        add(DG, 1,0,0,0, 1, ST_IDLE, 0,   0, 0, 0, 0);
        add(DG, 0,1,0,0, 1, ST_LOAD, 0,   0, 0, 1, 0);
        add(DG, 0,1,0,0, 5, ST_PLAY, 440, 1, 0, 1, 0);
        add(DG, 0,1,1,0, 2, ST_IDLE, 0,   0, 0, 0, 0);
        add(DG, 0,0,0,0, 1, ST_IDLE, 0,   0, 0, 0, 0);
        // 5) reset mid-note, then a full replay from address 0; 6) gap behaviour
        add(DG, 0,1,0,0, 1, ST_LOAD, 0,   0, 0, 1, 0);
        add(DG, 0,1,0,0, 3, ST_PLAY, 440, 1, 0, 1, 0);
        add(DG, 1,1,0,0, 1, ST_IDLE, 0,   0, 0, 0, 0);
        add(DG, 0,1,0,0, 1, ST_LOAD, 0,   0, 0, 1, 0);
`ifdef SECUENCIADOR_GAP_EN
        add(DG, 0,1,0,0, 8, ST_PLAY, 440, 1, 0, 1, 0);
        add(DG, 0,1,0,0, 4, ST_GAP,  0,   0, 0, 1, 0);
`else
        add(DG, 0,1,0,0, 12, ST_PLAY, 440, 1, 0, 1, 0);
`endif
        add(DG, 0,1,0,0, 1, ST_LOAD, 0,   0, 1, 1, 0);
        add(DG, 0,1,0,0, 4, ST_PLAY, 440, 1, 1, 1, 0);
        add(DG, 0,1,0,0, 1, ST_LOAD, 0,   0, 2, 1, 0);
        add(DG, 0,1,0,0, 1, ST_DONE, 0,   0, 2, 0, 1);
        add(DG, 0,0,0,0, 1, ST_IDLE, 0,   0, 2, 0, 0);

        // ---- apply the table
        for (int v = 0; v < vecs.size(); v++) begin
            int d;
            d = vecs[v].dut;
            rst  = vecs[v].r;
            play = vecs[v].p;
            stop = vecs[v].s;
            loop = vecs[v].l;
            for (int c = 0; c < vecs[v].n; c++) begin
                @(posedge clk);
                #1;
                check("state",    v, 32'(o_st[d]),   32'(vecs[v].st));
                check("freq",     v, o_freq[d],      vecs[v].freq);
                check("sound_en", v, 32'(o_snd[d]),  32'(vecs[v].snd));
                check("note_idx", v, 32'(o_idx[d]),  vecs[v].idx);
                check("busy",     v, 32'(o_busy[d]), 32'(vecs[v].busy));
                check("done",     v, 32'(o_done[d]), 32'(vecs[v].done));
            end
        end

        // ---- hand sequence: wrap past the last ROM entry, duration 0 as 1 tick
        rst = 1'b1; play = 1'b0; stop = 1'b0; loop = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_reset_state", 0, 32'(o_st[DW]), 32'(ST_IDLE));
        rst  = 1'b0;
        play = 1'b1;
        cyc = 0;
        got_done = 1'b0;
        while ((cyc < 60) && !got_done) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 5) check("wrap_dur0_freq", cyc, o_freq[DW], 262);
            if (cyc == 6) begin
                check("wrap_dur0_state", cyc, 32'(o_st[DW]), 32'(ST_LOAD));
                check("wrap_dur0_idx", cyc, 32'(o_idx[DW]), 1);
            end
            if (o_done[DW]) got_done = 1'b1;
        end
        check("wrap_done_seen", cyc, 32'(got_done), 1);
        check("wrap_done_cycle", cyc, cyc, 42);
        check("wrap_done_idx", cyc, 32'(o_idx[DW]), 7);
        @(posedge clk);
        #1;
        check("wrap_done_single", cyc, 32'(o_done[DW]), 0);
        play = 1'b0;
        @(posedge clk);
        #1;
        check("wrap_back_idle", cyc, 32'(o_st[DW]), 32'(ST_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
